// File: rtl/lfsr_prng.sv
// rtl/lfsr_prng.sv - multi-bit-per-cycle Fibonacci/Galois LFSR generator with a
// registered ready/valid output word, zero-state recovery and an accepted-word counter.
module lfsr_prng #(
  parameter int               WIDTH = 32,
  parameter int               OUT_W = 8,
  parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b1}},
  parameter int               CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] poly,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             lockup,
  output logic [CNT_W-1:0] word_cnt
);

  logic [WIDTH-1:0] state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             lockup_q, lockup_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

  logic [WIDTH-1:0] next_state;
  logic [OUT_W-1:0] next_word;
  logic             advance;
  logic             accept;

  // Unroll OUT_W single steps; the first bit shifted out lands in the word MSB.
  always_comb begin : step_unroll
    logic [WIDTH-1:0] s;
    logic             b;
    s         = state_q;
    b         = 1'b0;
    next_word = '0;
    for (int i = 0; i < OUT_W; i++) begin
      b                      = s[WIDTH-1];
      next_word[OUT_W-1-i]   = b;
      if (mode) begin
        s = {s[WIDTH-2:0], 1'b0} ^ (b ? poly : '0);
      end else begin
        s = {s[WIDTH-2:0], ^(s & poly)};
      end
    end
    next_state = s;
  end

  assign accept  = out_valid_q && out_ready;
  assign advance = en && !seed_load && (!out_valid_q || out_ready);

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    lockup_d    = 1'b0;
    word_cnt_d  = word_cnt_q;

    if (accept) begin
      word_cnt_d = word_cnt_q + CNT_W'(1);
    end

    if (seed_load) begin
      // A zero seed would stall the register forever, so fall back to SEED.
      if (seed_data == '0) begin
        state_d  = SEED;
        lockup_d = 1'b1;
      end else begin
        state_d = seed_data;
      end
      out_valid_d = 1'b0;
      word_cnt_d  = '0;
    end else if (advance) begin
      if (next_state == '0) begin
        state_d  = SEED;
        lockup_d = 1'b1;
      end else begin
        state_d = next_state;
      end
      out_data_d  = next_word;
      out_valid_d = 1'b1;
    end else if (accept) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEED;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      lockup_q    <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      lockup_q    <= lockup_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign lockup    = lockup_q;
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_lfsr_prng.sv
// tb/tb_lfsr_prng.sv - bench for lfsr_prng: directed 4-bit cases and randomized 32-bit traffic against a reference model
module tb_lfsr_prng;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic       a_rst, a_en, a_mode, a_seed_load, a_out_ready;
  logic [3:0] a_poly, a_seed_data;
  logic       a_out_valid, a_lockup;
  logic [0:0] a_out_data;
  logic [3:0] a_word_cnt;

  lfsr_prng #(.WIDTH(4), .OUT_W(1), .CNT_W(4)) u_a (
    .clk(clk), .rst(a_rst), .en(a_en), .mode(a_mode), .poly(a_poly),
    .seed_load(a_seed_load), .seed_data(a_seed_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .lockup(a_lockup),
    .word_cnt(a_word_cnt)
  );

  logic       b_rst, b_en, b_mode, b_seed_load, b_out_ready;
  logic [3:0] b_poly, b_seed_data;
  logic       b_out_valid, b_lockup;
  logic [3:0] b_out_data;
  logic [7:0] b_word_cnt;

  lfsr_prng #(.WIDTH(4), .OUT_W(4), .CNT_W(8)) u_b (
    .clk(clk), .rst(b_rst), .en(b_en), .mode(b_mode), .poly(b_poly),
    .seed_load(b_seed_load), .seed_data(b_seed_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .lockup(b_lockup),
    .word_cnt(b_word_cnt)
  );

  logic        c_rst, c_en, c_mode, c_seed_load, c_out_ready;
  logic [31:0] c_poly, c_seed_data;
  logic        c_out_valid, c_lockup;
  logic [7:0]  c_out_data;
  logic [15:0] c_word_cnt;

  lfsr_prng #(.WIDTH(32), .OUT_W(8), .CNT_W(16)) u_c (
    .clk(clk), .rst(c_rst), .en(c_en), .mode(c_mode), .poly(c_poly),
    .seed_load(c_seed_load), .seed_data(c_seed_data), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_data(c_out_data), .lockup(c_lockup),
    .word_cnt(c_word_cnt)
  );

  function automatic void model_step(input logic [63:0] s_in, input logic [63:0] p,
                                     input bit m, input int w, input int ow,
                                     output logic [63:0] s_out, output logic [63:0] word);
    logic [63:0] mask;
    logic [63:0] s;
    logic        b;
    logic        fb;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    s    = s_in & mask;
    word = '0;
    for (int k = 0; k < ow; k++) begin
      b    = s[w-1];
      word = {word[62:0], b};
      if (m) begin
        s = ((s << 1) & mask) ^ (b ? (p & mask) : 64'd0);
      end else begin
        fb = 1'($countones(s & p & mask) % 2);
        s  = ((s << 1) & mask) | {63'd0, fb};
      end
    end
    s_out = s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  fib_states [5] = '{4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1101};
  logic        fib_bits   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [63:0] ms, mw;
  logic [63:0] m_state, m_data, m_cnt;
  bit          m_valid, m_lock, m_acc, m_adv;

  initial begin
    a_rst = 1; a_en = 0; a_mode = 0; a_poly = 0; a_seed_load = 0; a_seed_data = 0; a_out_ready = 0;
    b_rst = 1; b_en = 0; b_mode = 0; b_poly = 0; b_seed_load = 0; b_seed_data = 0; b_out_ready = 0;
    c_rst = 1; c_en = 0; c_mode = 0; c_poly = 0; c_seed_load = 0; c_seed_data = 0; c_out_ready = 0;
    tick();

    chk("rst_valid", a_out_valid, 1'b0);
    chk("rst_data", a_out_data, 1'b0);
    chk("rst_lockup", a_lockup, 1'b0);
    chk("rst_cnt", a_word_cnt, 4'd0);
    chk("rst_state", u_a.state_q, 4'hF);
    a_rst = 0; b_rst = 0; c_rst = 0;

    a_poly = 4'b1001; a_seed_load = 1; a_seed_data = 4'b0001;
    tick();
    chk("fib_seed_state", u_a.state_q, 4'b0001);
    chk("fib_seed_valid", a_out_valid, 1'b0);
    a_seed_load = 0; a_en = 1; a_out_ready = 1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (i < 5) begin
        chk("fib_state", u_a.state_q, fib_states[i]);
        chk("fib_bit", a_out_data, fib_bits[i]);
      end
      chk("fib_nonzero", (u_a.state_q != 4'd0), 1'b1);
      chk("fib_valid", a_out_valid, 1'b1);
    end
    chk("fib_period", u_a.state_q, 4'b0001);
    chk("fib_cnt", a_word_cnt, 4'd14);

    a_seed_load = 1; a_seed_data = 4'b1000; a_mode = 1; a_poly = 4'b0011;
    tick();
    chk("gal_seed_state", u_a.state_q, 4'b1000);
    chk("gal_seed_valid", a_out_valid, 1'b0);
    chk("gal_seed_cnt", a_word_cnt, 4'd0);
    a_seed_load = 0;
    tick();
    chk("gal_data", a_out_data, 1'b1);
    chk("gal_state", u_a.state_q, 4'b0011);
    chk("gal_valid", a_out_valid, 1'b1);

    a_out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      a_poly = 4'($urandom_range(0, 15));
      a_mode = 1'($urandom_range(0, 1));
      tick();
      chk("bp_data", a_out_data, 1'b1);
      chk("bp_state", u_a.state_q, 4'b0011);
      chk("bp_valid", a_out_valid, 1'b1);
      chk("bp_cnt", a_word_cnt, 4'd0);
    end
    a_mode = 1; a_poly = 4'b0011; a_out_ready = 1;
    tick();
    chk("bp_release_cnt", a_word_cnt, 4'd1);
    chk("bp_release_state", u_a.state_q, 4'b0110);
    chk("bp_release_data", a_out_data, 1'b0);

    a_seed_load = 1; a_seed_data = 4'b0101; a_mode = 0; a_poly = 4'b1001; a_en = 0;
    tick();
    chk("cnt_seed_cnt", a_word_cnt, 4'd0);
    a_seed_load = 0; a_en = 1; a_out_ready = 1;
    for (int i = 0; i < 18; i++) tick();
    chk("cnt_wrap", a_word_cnt, 4'd1);
    ms = 64'd5;
    mw = 64'd0;
    for (int i = 0; i < 18; i++) model_step(ms, 64'd9, 1'b0, 4, 1, ms, mw);
    chk("cnt_pre_state", u_a.state_q, ms[3:0]);
    a_seed_load = 1; a_seed_data = 4'b0110;
    tick();
    chk("cnt_clear_wins", a_word_cnt, 4'd0);
    chk("seed_clears_valid", a_out_valid, 1'b0);
    chk("seed_holds_data", a_out_data, mw[0]);
    chk("seed_state", u_a.state_q, 4'b0110);

    a_seed_load = 0; a_en = 1; a_out_ready = 0;
    tick();
    chk("en_adv_state", u_a.state_q, 4'b1100);
    chk("en_adv_valid", a_out_valid, 1'b1);
    a_en = 0; a_out_ready = 1;
    tick();
    chk("en_low_valid", a_out_valid, 1'b0);
    chk("en_low_cnt", a_word_cnt, 4'd1);
    chk("en_low_state", u_a.state_q, 4'b1100);

    a_en = 1; a_out_ready = 0;
    tick();
    chk("mid_valid", a_out_valid, 1'b1);
    chk("mid_data", a_out_data, 1'b1);
    a_rst = 1; a_seed_load = 1; a_seed_data = 4'b0010;
    tick();
    chk("mid_rst_valid", a_out_valid, 1'b0);
    chk("mid_rst_data", a_out_data, 1'b0);
    chk("mid_rst_cnt", a_word_cnt, 4'd0);
    chk("mid_rst_state", u_a.state_q, 4'hF);
    a_rst = 0;

    a_en = 0; a_seed_load = 1; a_seed_data = 4'b0000;
    tick();
    chk("zseed_state", u_a.state_q, 4'hF);
    chk("zseed_lockup", a_lockup, 1'b1);
    a_seed_load = 0;
    tick();
    chk("zseed_lockup_end", a_lockup, 1'b0);
    chk("zseed_state_hold", u_a.state_q, 4'hF);

    b_seed_load = 1; b_seed_data = 4'b0001; b_poly = 4'b0000; b_mode = 0;
    tick();
    chk("b_seed_lockup", b_lockup, 1'b0);
    b_seed_load = 0; b_en = 1; b_out_ready = 1;
    tick();
    chk("b_zero_data", b_out_data, 4'b0001);
    chk("b_zero_state", u_b.state_q, 4'hF);
    chk("b_zero_lockup", b_lockup, 1'b1);
    chk("b_zero_valid", b_out_valid, 1'b1);
    b_en = 0;
    tick();
    chk("b_lockup_end", b_lockup, 1'b0);
    chk("b_cnt", b_word_cnt, 8'd1);

    m_state = 64'hFFFF_FFFF; m_data = 0; m_cnt = 0; m_valid = 0; m_lock = 0;
    for (int i = 0; i < 400; i++) begin
      c_rst       = ($urandom_range(0, 59) == 0);
      c_en        = ($urandom_range(0, 3) != 0);
      c_mode      = 1'($urandom_range(0, 1));
      c_poly      = $urandom;
      c_seed_load = ($urandom_range(0, 19) == 0);
      c_seed_data = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      c_out_ready = ($urandom_range(0, 2) != 0);

      if (c_rst) begin
        m_state = 64'hFFFF_FFFF; m_valid = 0; m_data = 0; m_lock = 0; m_cnt = 0;
      end else if (c_seed_load) begin
        m_lock  = (c_seed_data == 32'd0);
        m_state = m_lock ? 64'hFFFF_FFFF : {32'd0, c_seed_data};
        m_valid = 0;
        m_cnt   = 0;
      end else begin
        m_acc  = m_valid && c_out_ready;
        m_adv  = c_en && (!m_valid || c_out_ready);
        m_lock = 0;
        if (m_acc) m_cnt = (m_cnt + 1) % 65536;
        if (m_adv) begin
          model_step(m_state, {32'd0, c_poly}, c_mode, 32, 8, ms, mw);
          m_lock  = (ms == 0);
          m_state = m_lock ? 64'hFFFF_FFFF : ms;
          m_data  = mw;
          m_valid = 1;
        end else if (m_acc) begin
          m_valid = 0;
        end
      end
      tick();
      chk("rnd_valid", c_out_valid, m_valid);
      chk("rnd_data", c_out_data, m_data);
      chk("rnd_lockup", c_lockup, m_lock);
      chk("rnd_cnt", c_word_cnt, m_cnt);
      chk("rnd_state", u_c.state_q, m_state);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lfsr_prng.md
LFSR_PRNG -- requirements
Module: lfsr_prng

Interface
REQ-001 Parameter WIDTH, default 32, LFSR state width, legal range 4..64.
REQ-002 Parameter OUT_W, default 8, bits produced per output word, legal range 1..WIDTH.
REQ-003 Parameter SEED, default all ones (WIDTH bits), reset/recovery state, SHALL be non-zero.
REQ-004 Parameter CNT_W, default 32, width of the accepted-word counter.
REQ-005 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 Port rst  input  1  synchronous, active-high reset.
REQ-007 Port en  input  1  permits the generator to advance.
REQ-008 Port mode  input  1  0 = Fibonacci step, 1 = Galois step; sampled on each advance.
REQ-009 Port poly  input  WIDTH  tap mask; bit i set = tap i; sampled on each advance.
REQ-010 Port seed_load  input  1  loads seed_data into the state.
REQ-011 Port seed_data  input  WIDTH  seed value.
REQ-012 Port out_valid  output  1  out_data holds an unconsumed word.
REQ-013 Port out_ready  input  1  consumer accepts out_data.
REQ-014 Port out_data  output  OUT_W  generated word.
REQ-015 Port lockup  output  1  one-cycle pulse when a zero state was replaced by SEED.
REQ-016 Port word_cnt  output  CNT_W  count of accepted words (out_valid && out_ready).

Function
REQ-017 Fibonacci single step SHALL be: output bit = S[WIDTH-1], fb = XOR-reduce(S & poly), S' = {S[WIDTH-2:0], fb}.
REQ-018 Galois single step SHALL be: output bit b = S[WIDTH-1], S' = {S[WIDTH-2:0], 0} XOR (b ? poly : 0).
REQ-019 An advance SHALL apply OUT_W single steps in one cycle, with the first output bit in out_data[OUT_W-1] and the last in out_data[0].
REQ-020 An advance SHALL occur when en && !seed_load && (!out_valid || out_ready).
REQ-021 On an advance, out_data SHALL register the new word and out_valid SHALL be 1 on the next cycle; the word-to-valid latency is 1 cycle.
REQ-022 When out_valid && out_ready and no advance occurs, out_valid SHALL clear on the next cycle.
REQ-023 While out_valid && !out_ready, out_data, out_valid, and the state SHALL hold unchanged.
REQ-024 seed_load SHALL have priority over an advance.
REQ-025 On seed_load, the state SHALL be set to seed_data, out_valid SHALL clear, word_cnt SHALL clear, and out_data SHALL hold its value.
REQ-026 If a loaded seed_data is zero, the state SHALL be set to SEED instead and lockup SHALL pulse for 1 cycle.
REQ-027 If an advance yields an all-zero next state, the state SHALL be set to SEED instead, lockup SHALL pulse for 1 cycle, and the produced word SHALL still be output.
REQ-028 word_cnt SHALL increment by 1 on each accepted word, wrap modulo 2^CNT_W, and clear on rst or seed_load.
REQ-029 A seed_load in the same cycle as an accepted word SHALL clear word_cnt; the clear wins.
REQ-030 Changes to mode or poly SHALL affect only subsequent advances and SHALL never alter a pending out_data.
REQ-031 When en is low, the state SHALL be frozen, and a pending word SHALL still be consumable.

Reset
REQ-032 While rst is high: state = SEED, out_valid = 0, out_data = 0, lockup = 0, word_cnt = 0.
REQ-033 rst SHALL override seed_load and advance.
REQ-034 An asserted rst SHALL discard a pending word.
REQ-035 The first advance MAY occur in the cycle after rst deasserts.

Verification
REQ-036 Reset: assert rst mid-stream with out_valid = 1 -> next cycle out_valid = 0, out_data = 0, word_cnt = 0, state = SEED.
REQ-037 Fibonacci period: WIDTH = 4, OUT_W = 1, poly = 4'b1001, load seed 4'b0001, en = 1, out_ready = 1 -> states 0011, 0111, 1111, 1110, 1101, ...; after 15 advances the state returns to 0001, 0000 never occurs, and the first out_data bits are 0, 0, 0, 1, 1.
REQ-038 Galois step: WIDTH = 4, mode = 1, poly = 4'b0011, seed 4'b1000 -> one advance gives out_data = 1 and state = 0011.
REQ-039 Backpressure: out_ready = 0 for 3 cycles while out_valid = 1 -> out_data and the state are stable; on out_ready = 1, word_cnt goes 0 -> 1.
REQ-040 Lockup: seed_load with seed_data = 0 -> state = SEED, lockup high for exactly 1 cycle; poly = 0 with WIDTH = 4, OUT_W = 4, Fibonacci, seed 4'b0001 -> the next state is zero, so state = SEED and lockup pulses.
REQ-041 Counter: CNT_W = 4, accept 17 words -> word_cnt = 1; seed_load in the same cycle as an accept -> word_cnt = 0.
